// File: rtl/fir_sched_pkg.sv
// Shared widths, FSM encoding and default coefficients for the fir_sched block.
package fir_sched_pkg;

  localparam int unsigned NCH_DEF   = 4;
  localparam int unsigned NTAPS_DEF = 4;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ACC_W     = 16;
  localparam int unsigned PROD_W    = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Reset/default coefficient set h = {1,2,3,4}; taps beyond the fourth default to zero.
  function automatic logic [DATA_W-1:0] def_coef(int unsigned k);
    case (k)
      0:       return DATA_W'(1);
      1:       return DATA_W'(2);
      2:       return DATA_W'(3);
      3:       return DATA_W'(4);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/fir_rr_arb.sv
// Round-robin one-hot arbiter; search starts one past the last accepted grant.
module fir_rr_arb #(
  parameter int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic          accept,
  output logic [N-1:0]  grant_c,
  output logic [IW-1:0] grant_idx_c
);

  logic [IW-1:0] ptr;
  logic          found;

  function automatic logic [IW-1:0] wrap_add(logic [IW-1:0] a, int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    return IW'(s % N);
  endfunction

  // First requester at or after the pointer wins.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    found       = 1'b0;
    if (en) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && req[wrap_add(ptr, i)]) begin
          found       = 1'b1;
          grant_idx_c = wrap_add(ptr, i);
        end
      end
      if (found) grant_c = N'(1) << grant_idx_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       ptr <= '0;
    else if (accept) ptr <= wrap_add(grant_idx_c, 1);
  end

endmodule

// File: rtl/fir_sched.sv
// Multi-channel FIR with one shared 8x8 MAC, round-robin channel scheduling.
// Define FIR_SCHED_COEF_LOAD_EN to add the runtime coefficient write port.
module fir_sched
  import fir_sched_pkg::*;
#(
  parameter int unsigned NCH   = NCH_DEF,
  parameter int unsigned NTAPS = NTAPS_DEF,
  localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned TW   = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        in_valid,
  input  logic [NCH*DATA_W-1:0] in_data,
  output logic [NCH-1:0]        in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_data,
  output logic [CW-1:0]         out_ch,
  output logic                  busy
`ifdef FIR_SCHED_COEF_LOAD_EN
  ,
  input  logic                  coef_we,
  input  logic [TW-1:0]         coef_addr,
  input  logic [DATA_W-1:0]     coef_data
`endif
);

  state_t              state, state_next;
  logic [DATA_W-1:0]   taps [NCH][NTAPS];
  logic [DATA_W-1:0]   coef [NTAPS];
  logic [ACC_W-1:0]    acc;
  logic [TW-1:0]       tap_cnt;
  logic [CW-1:0]       cur_ch;

  logic [NCH-1:0]      grant_c;
  logic [CW-1:0]       grant_idx_c;
  logic                transfer_c, last_tap_c, load_out_c, out_done_c;
  logic [PROD_W-1:0]   prod_c;
  logic [ACC_W:0]      sum_c;
  logic [ACC_W-1:0]    acc_sat_c;

  fir_rr_arb #(.N(NCH)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (in_valid),
    .en          (state == IDLE),
    .accept      (transfer_c),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c)
  );

  assign in_ready   = grant_c;
  assign transfer_c = |(in_valid & grant_c);
  assign busy       = (state != IDLE);
  assign last_tap_c = (tap_cnt == TW'(NTAPS - 1));

  // Saturating unsigned MAC step for the current tap.
  always_comb begin
    prod_c    = PROD_W'(coef[tap_cnt]) * PROD_W'(taps[cur_ch][tap_cnt]);
    sum_c     = (ACC_W + 1)'(acc) + (ACC_W + 1)'(prod_c);
    acc_sat_c = sum_c[ACC_W] ? '1 : sum_c[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_out_c = 1'b0;
    out_done_c = 1'b0;
    unique case (state)
      IDLE: if (transfer_c) state_next = MAC;
      MAC: begin
        if (last_tap_c) begin
          state_next = OUT;
          load_out_c = 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_next = IDLE;
          out_done_c = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      tap_cnt   <= '0;
      cur_ch    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      for (int unsigned c = 0; c < NCH; c++)
        for (int unsigned k = 0; k < NTAPS; k++)
          taps[c][k] <= '0;
    end else begin
      // Only the granted channel's delay line shifts.
      if (transfer_c) begin
        acc     <= '0;
        tap_cnt <= '0;
        cur_ch  <= grant_idx_c;
        taps[grant_idx_c][0] <= in_data[grant_idx_c*DATA_W +: DATA_W];
        for (int unsigned k = 1; k < NTAPS; k++)
          taps[grant_idx_c][k] <= taps[grant_idx_c][k-1];
      end
      if (state == MAC) begin
        acc     <= acc_sat_c;
        tap_cnt <= tap_cnt + 1'b1;
      end
      if (load_out_c) begin
        out_valid <= 1'b1;
        out_data  <= acc_sat_c;
        out_ch    <= cur_ch;
      end else if (out_done_c) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef FIR_SCHED_COEF_LOAD_EN
  // Writes land only in IDLE, so a same-cycle transfer already sees the new value in MAC.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NTAPS; k++) coef[k] <= def_coef(k);
    end else if (coef_we && state == IDLE) begin
      coef[coef_addr] <= coef_data;
    end
  end
`else
  always_comb begin
    for (int unsigned k = 0; k < NTAPS; k++) coef[k] = def_coef(k);
  end
`endif

endmodule

// File: tb/tb_fir_sched.sv
// Self-checking bench for fir_sched: vector table plus scoreboard with a reference model.
module tb_fir_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic        busy;
`ifdef FIR_SCHED_COEF_LOAD_EN
  logic        coef_we;
  logic [1:0]  coef_addr;
  logic [7:0]  coef_data;
`endif

  fir_sched dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .busy      (busy)
`ifdef FIR_SCHED_COEF_LOAD_EN
    ,
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct { int ch; int data; int t; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] m_taps [4][4];
  logic [7:0] m_coef [4];
  int         m_ptr;
  bit         holding;

  function automatic logic [3:0] rr_pick(input int ptr, input logic [3:0] req);
    for (int i = 0; i < 4; i++) begin
      if (req[(ptr + i) % 4]) return 4'(1 << ((ptr + i) % 4));
    end
    return 4'b0;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 4; k++) m_taps[c][k] = 8'd0;
      for (int k = 0; k < 4; k++) m_coef[k] = 8'(k + 1);
      m_ptr   = 0;
      holding = 1'b0;
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          check("sb_data", 32'(out_data), 32'(exp_q[0].data));
          check("sb_ch", 32'(out_ch), 32'(exp_q[0].ch));
          if (!holding) check("sb_latency", 32'(cyc), 32'(exp_q[0].t + 5));
        end
        if (out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          holding = 1'b0;
        end else begin
          holding = 1'b1;
        end
      end
      if (!busy) begin
        logic [3:0] eg;
        int g;
        int s;
`ifdef FIR_SCHED_COEF_LOAD_EN
        if (coef_we) m_coef[coef_addr] = coef_data;
`endif
        eg = rr_pick(m_ptr, in_valid);
        check("sb_in_ready", 32'(in_ready), 32'(eg));
        if (eg != 4'b0) begin
          g = 0;
          for (int i = 0; i < 4; i++) if (eg[i]) g = i;
          for (int k = 3; k > 0; k--) m_taps[g][k] = m_taps[g][k-1];
          m_taps[g][0] = in_data[g*8 +: 8];
          s = 0;
          for (int k = 0; k < 4; k++) s += int'(m_coef[k]) * int'(m_taps[g][k]);
          if (s > 65535) s = 65535;
          exp_q.push_back('{g, s, cyc});
          m_ptr = (g + 1) % 4;
        end
      end else begin
        check("busy_in_ready", 32'(in_ready), 32'd0);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 4'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic send(input int ch, input logic [7:0] sample);
    bit ok;
    @(posedge clk); #1;
    in_data[ch*8 +: 8] = sample;
    in_valid[ch] = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (in_ready[ch]) ok = 1'b1;
    end
    if (!ok) check("grant_timeout", 32'(in_ready[ch]), 32'd1);
    @(posedge clk); #1;
    in_valid[ch] = 1'b0;
  endtask

  task automatic wait_out(output logic [15:0] d, output logic [1:0] c);
    bit ok;
    ok = 1'b0;
    d = 16'hxxxx;
    c = 2'bxx;
    for (int t = 0; t < 30 && !ok; t++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        d = out_data;
        c = out_ch;
      end
    end
    if (!ok) check("out_timeout", 32'(out_valid), 32'd1);
  endtask

  typedef struct { bit rst; int ch; logic [7:0] sample; logic [15:0] exp; } vec_t;
  vec_t vt [8];

  initial begin
    logic [15:0] d;
    logic [1:0]  c;
    bit          seen;

    vt[0] = '{1'b0, 0, 8'd1,  16'd1};
    vt[1] = '{1'b0, 0, 8'd2,  16'd4};
    vt[2] = '{1'b0, 0, 8'd3,  16'd10};
    vt[3] = '{1'b0, 0, 8'd4,  16'd20};
    vt[4] = '{1'b0, 0, 8'd5,  16'd30};
    vt[5] = '{1'b1, 0, 8'd1,  16'd1};
    vt[6] = '{1'b0, 1, 8'd10, 16'd10};
    vt[7] = '{1'b0, 0, 8'd2,  16'd4};

    reset = 1'b1; in_valid = 4'b0; in_data = 32'b0; out_ready = 1'b1;
`ifdef FIR_SCHED_COEF_LOAD_EN
    coef_we = 1'b0; coef_addr = 2'b0; coef_data = 8'b0;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);

    // Channel-0 ramp, then interleaved channels after a fresh reset
    for (int i = 0; i < 8; i++) begin
      if (vt[i].rst) do_reset();
      send(vt[i].ch, vt[i].sample);
      wait_out(d, c);
      check("tbl_data", 32'(d), 32'(vt[i].exp));
      check("tbl_ch", 32'(c), 32'(vt[i].ch));
    end

    // All channels requesting: grants rotate 0,1,2,3,0
    do_reset();
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) in_data[k*8 +: 8] = 8'(10 * (k + 1));
    in_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
        @(negedge clk);
        if (|in_ready) seen = 1'b1;
      end
      check("rr_grant", 32'(in_ready), 32'(1 << (n % 4)));
      wait_out(d, c);
      check("rr_out_ch", 32'(c), 32'(n % 4));
    end
    @(posedge clk); #1;
    in_valid = 4'b0;

    // Back-pressure: result held while out_ready is low
    do_reset();
    out_ready = 1'b0;
    send(0, 8'd9);
    wait_out(d, c);
    check("stall_first", 32'(d), 32'd9);
    @(posedge clk); #1;
    in_valid = 4'hF;
    repeat (10) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'd9);
      check("stall_ch", 32'(out_ch), 32'd0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 4'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_busy", 32'(busy), 32'd0);
    check("release_hold_data", 32'(out_data), 32'd9);

    // Reset during the second MAC cycle discards the result
    do_reset();
    send(0, 8'd3);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mac_rst_no_valid", 32'(seen), 32'd0);
    send(0, 8'd7);
    wait_out(d, c);
    check("mac_rst_next", 32'(d), 32'd7);

`ifdef FIR_SCHED_COEF_LOAD_EN
    // All coefficients 255: saturation after the first sample
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      coef_we = 1'b1; coef_addr = 2'(k); coef_data = 8'd255;
    end
    @(posedge clk); #1;
    coef_we = 1'b0;
    for (int n = 0; n < 4; n++) begin
      send(2, 8'd255);
      wait_out(d, c);
      check("coef_sat", 32'(d), (n == 0) ? 32'hFE01 : 32'hFFFF);
      check("coef_sat_ch", 32'(c), 32'd2);
    end
`endif

    repeat (3) @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fir_sched.md
FIR_SCHED -- requirements
Module: fir_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, number of input sample channels.
REQ-002 SHALL have parameter NTAPS, default 4, taps per channel.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  NCH  per-channel sample valid.
REQ-006 SHALL have port in_data  input  NCH*8  per-channel unsigned 8-bit samples; channel c occupies bits [8c+7:8c].
REQ-007 SHALL have port in_ready  output  NCH  one-hot grant; a sample transfers when in_valid[c] and in_ready[c] are both high.
REQ-008 SHALL have port out_valid  output  1  filtered result valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-010 SHALL have port out_data  output  16  unsigned filtered result.
REQ-011 SHALL have port out_ch  output  log2(NCH)  channel of out_data.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL keep a private NTAPS-deep 8-bit delay line per channel and share one 8x8 multiply-accumulate unit across all channels.
REQ-014 SHALL use FSM states IDLE -> MAC -> OUT -> IDLE.
REQ-015 SHALL, in IDLE, assert in_ready for exactly one requesting channel, chosen round-robin starting at (last granted + 1) mod NCH; SHALL assert no in_ready outside IDLE.
REQ-016 SHALL, on a transfer, shift the sample into that channel's delay line, clear the accumulator, and enter MAC.
REQ-017 SHALL, in MAC, add h[k]*tap[g][k] for k = 0..NTAPS-1, one tap per cycle, where tap[g][0] is the newest sample; SHALL then enter OUT.
REQ-018 SHALL accumulate unsigned and saturate at 16'hFFFF; SHALL never wrap.
REQ-019 SHALL, in OUT, hold out_valid, out_data and out_ch stable until out_ready is high, then return to IDLE.
REQ-020 SHALL have a latency of NTAPS+1 cycles: a transfer in cycle T gives out_valid in cycle T+5 for NTAPS=4.
REQ-021 SHALL give a throughput of one sample per NTAPS+2 cycles when out_ready is held high.
REQ-022 SHALL leave the delay lines of non-granted channels unchanged.
REQ-023 SHALL keep out_data and out_ch holding their last values while out_valid is low.

Reset
REQ-024 SHALL, on reset, clear all delay lines and the accumulator, set state IDLE, set out_valid/out_data/out_ch to 0, and set the round-robin pointer so channel 0 wins first.
REQ-025 SHALL, on reset in MAC or OUT, discard the in-flight result without asserting out_valid.
REQ-026 SHALL, on reset, load default coefficients h = {1,2,3,4} (h[0] = 1).

Configuration
REQ-027 SHALL, with FIR_SCHED_COEF_LOAD_EN defined, add inputs coef_we (1), coef_addr (log2(NTAPS)) and coef_data (8).
REQ-028 SHALL, with FIR_SCHED_COEF_LOAD_EN defined, write coefficients only while in IDLE and ignore writes otherwise.
REQ-029 SHALL, with FIR_SCHED_COEF_LOAD_EN defined, have a write and a sample transfer in the same IDLE cycle both commit, and that sample SHALL use the new coefficient.
REQ-030 SHALL, without FIR_SCHED_COEF_LOAD_EN, omit those ports and use constant coefficients {1,2,3,4}.

Structure
REQ-031 SHALL place NCH/NTAPS defaults, data/accumulator widths, FSM state encoding and default coefficients in package fir_sched_pkg.
REQ-032 SHALL implement grant selection in sub-module fir_rr_arb (request vector, enable, one-hot grant, pointer update on accept).

Verification
REQ-033 SHALL cover: channel 0 only, samples 1,2,3,4,5, default coefficients, out_ready=1 -> out_data 1,4,10,20,30 with out_ch=0, each 5 cycles after its transfer.
REQ-034 SHALL cover: all in_valid high from reset -> grants in order 0,1,2,3,0; each out_ch matches its grant.
REQ-035 SHALL cover: out_ready low for 10 cycles in OUT -> out_valid/out_data/out_ch stable, in_ready all 0, busy=1.
REQ-036 SHALL cover, with FIR_SCHED_COEF_LOAD_EN: all coefficients 255, four 255 samples on channel 2 -> outputs 16'hFE01, 16'hFFFF, 16'hFFFF, 16'hFFFF.
REQ-037 SHALL cover: reset asserted in the 2nd MAC cycle -> no out_valid; next channel-0 sample 7 -> out_data 7.
REQ-038 SHALL cover: interleaved channel 0 (1,2) and channel 1 (10) -> channel-1 result 10, channel-0 results 1 then 4.
